// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 stream controller.
// SHA3_SHAKE_EN enables the SHAKE modes and the squeeze state.
package sha3_pkg;

    localparam int          BLK_W     = 1344;
    localparam int unsigned BLK_BYTES = BLK_W / 8;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_LAST     = 8'h80;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } sha3_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEND,
        ST_PERM,
        ST_OUT
`ifdef SHA3_SHAKE_EN
        , ST_SQZ
`endif
    } sha3_state_e;

    function automatic logic [7:0] rate_bytes(input logic [2:0] m);
        case (m)
            MODE_SHA3_224: return 8'd144;
            MODE_SHA3_256: return 8'd136;
            MODE_SHA3_384: return 8'd104;
            MODE_SHA3_512: return 8'd72;
            MODE_SHAKE128: return 8'd168;
            MODE_SHAKE256: return 8'd136;
            default:       return 8'd0;
        endcase
    endfunction

    function automatic logic [10:0] digest_bits(input logic [2:0] m);
        case (m)
            MODE_SHA3_224: return 11'd224;
            MODE_SHA3_256: return 11'd256;
            MODE_SHA3_384: return 11'd384;
            MODE_SHA3_512: return 11'd512;
            default:       return 11'd0;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [2:0] m);
`ifdef SHA3_SHAKE_EN
        return m <= MODE_SHAKE256;
`else
        return m <= MODE_SHA3_512;
`endif
    endfunction

    function automatic logic [7:0] suffix_of(input logic [2:0] m);
        return (m >= MODE_SHAKE128) ? SUFFIX_SHAKE : SUFFIX_SHA3;
    endfunction

endpackage

// File: rtl/sha3_blk_asm.sv
// Rate-block register: inserts message bytes at a byte offset and applies
// the domain-suffix / final-bit padding XOR. Same under SHA3_SHAKE_EN.
module sha3_blk_asm
    import sha3_pkg::*;
#(
    parameter int IN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [IN_W-1:0]  data_i,
    input  logic [7:0]       nbytes_i,
    input  logic [7:0]       off_i,
    input  logic             pad_i,
    input  logic [7:0]       pad_off_i,
    input  logic [7:0]       rate_i,
    input  logic [7:0]       suffix_i,
    output logic [BLK_W-1:0] blk_o
);

    logic [BLK_W-1:0] blk_q, blk_d;

    always_comb begin
        blk_d = clr_i ? '0 : blk_q;
        if (wr_i) begin
            for (int unsigned k = 0; k < IN_W / 8; k++) begin
                if (k < 32'(nbytes_i) && 32'(off_i) + k < BLK_BYTES)
                    blk_d[(32'(off_i) + k) * 8 +: 8] = data_i[k * 8 +: 8];
            end
        end
        // Both XORs land on the same byte when one message byte short of a full block.
        if (pad_i) begin
            if (32'(pad_off_i) < BLK_BYTES)
                blk_d[32'(pad_off_i) * 8 +: 8] ^= suffix_i;
            if (rate_i != 8'd0 && 32'(rate_i) <= BLK_BYTES)
                blk_d[(32'(rate_i) - 1) * 8 +: 8] ^= PAD_LAST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blk_q <= '0;
        else     blk_q <= blk_d;
    end

    assign blk_o = blk_q;

endmodule

// File: rtl/sha3_stream_ctrl.sv
// SHA-3 / SHAKE streaming controller: absorbs message beats into rate blocks,
// hands them to the permutation engine and streams digest chunks (SHAKE with SHA3_SHAKE_EN).
module sha3_stream_ctrl
    import sha3_pkg::*;
#(
    parameter int IN_W   = 64,
    parameter int OLEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              mode_i,
    input  logic [OLEN_W-1:0]       out_len_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_last,
    input  logic [$clog2(IN_W/8):0] in_bytes,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [BLK_W-1:0]        blk_data,
    output logic                    blk_first,
    output logic                    blk_squeeze,
    input  logic                    perm_done,
    input  logic [BLK_W-1:0]        state_i,
    output logic                    dig_valid,
    input  logic                    dig_ready,
    output logic [BLK_W-1:0]        dig_data,
    output logic [10:0]             dig_len,
    output logic                    dig_last,
    output logic                    busy,
    output logic                    err
);

    localparam logic [7:0] BEAT_BYTES = 8'(IN_W / 8);

    sha3_state_e      state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [7:0]       rate_q, rate_d, off_q, off_d;
    logic             final_q, final_d, padp_q, padp_d, first_q, first_d;
    logic             drop_q, drop_d, err_q, err_d;
    logic [BLK_W-1:0] dig_q, dig_d;

    logic       clr, wr, pad, take;
    logic [7:0] pad_off, beat_nb, base_off, new_off, rate_c, sfx_c;

`ifdef SHA3_SHAKE_EN
    logic [OLEN_W-1:0]  rem_q, rem_d;
    logic               sent_q, sent_d;
    logic [10:0]        rate_bits;
    logic [OLEN_W+10:0] rem_x, rb_x;

    assign rate_bits = {rate_q, 3'b000};
    assign rem_x     = {11'd0, rem_q};
    assign rb_x      = {{OLEN_W{1'b0}}, rate_bits};
`else
    logic unused_out_len;
    assign unused_out_len = ^out_len_i;
`endif

    assign rate_c   = (state_q == ST_IDLE) ? rate_bytes(mode_i) : rate_q;
    assign sfx_c    = suffix_of((state_q == ST_IDLE) ? mode_i : mode_q);
    assign base_off = (state_q == ST_IDLE) ? 8'd0 : off_q;
    assign beat_nb  = in_last ? 8'(in_bytes) : BEAT_BYTES;
    assign new_off  = base_off + beat_nb;

    always_comb begin
        state_d = state_q;  mode_d  = mode_q;  rate_d  = rate_q;  off_d   = off_q;
        final_d = final_q;  padp_d  = padp_q;  first_d = first_q; drop_d  = drop_q;
        err_d   = err_q;    dig_d   = dig_q;
`ifdef SHA3_SHAKE_EN
        rem_d   = rem_q;    sent_d  = sent_q;
`endif
        clr = 1'b0;  wr = 1'b0;  pad = 1'b0;  pad_off = '0;  take = 1'b0;

        unique case (state_q)
            ST_IDLE: if (in_valid) begin
                err_d = !mode_legal(mode_i);
                if (mode_legal(mode_i)) begin
                    mode_d  = mode_i;
                    rate_d  = rate_c;
                    first_d = 1'b1;
                    clr     = 1'b1;
                    take    = 1'b1;
`ifdef SHA3_SHAKE_EN
                    rem_d   = out_len_i;
`endif
                end else if (!in_last) begin
                    drop_d  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: if (in_valid) begin
                if (!drop_q) begin
                    take = 1'b1;
                end else if (in_last) begin
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: if (blk_ready) begin
                first_d = 1'b0;
                state_d = ST_PERM;
            end
            ST_PERM: if (perm_done) begin
                if (final_q) begin
                    dig_d   = state_i;
                    off_d   = '0;
                    state_d = ST_OUT;
                end else if (padp_q) begin
                    // Message ended on a rate boundary: emit the padding-only block.
                    clr     = 1'b1;
                    pad     = 1'b1;
                    final_d = 1'b1;
                    padp_d  = 1'b0;
                    state_d = ST_SEND;
                end else begin
                    clr     = 1'b1;
                    off_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_OUT: if (dig_ready) begin
`ifdef SHA3_SHAKE_EN
                if (dig_last) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = OLEN_W'(rem_x - rb_x);
                    sent_d  = 1'b0;
                    state_d = ST_SQZ;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SHA3_SHAKE_EN
            ST_SQZ: begin
                if (!sent_q && blk_ready) sent_d = 1'b1;
                if (sent_q && perm_done) begin
                    dig_d   = state_i;
                    state_d = ST_OUT;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            wr    = 1'b1;
            off_d = new_off;
            if (in_last) begin
                final_d = (new_off != rate_c);
                padp_d  = (new_off == rate_c);
                pad     = (new_off != rate_c);
                pad_off = new_off;
                state_d = ST_SEND;
            end else if (new_off == rate_c) begin
                final_d = 1'b0;
                padp_d  = 1'b0;
                state_d = ST_SEND;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            rate_q  <= '0;
            off_q   <= '0;
            final_q <= 1'b0;
            padp_q  <= 1'b0;
            first_q <= 1'b0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            dig_q   <= '0;
`ifdef SHA3_SHAKE_EN
            rem_q   <= '0;
            sent_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            off_q   <= off_d;
            final_q <= final_d;
            padp_q  <= padp_d;
            first_q <= first_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            dig_q   <= dig_d;
`ifdef SHA3_SHAKE_EN
            rem_q   <= rem_d;
            sent_q  <= sent_d;
`endif
        end
    end

    always_comb begin
        dig_len  = '0;
        dig_last = 1'b0;
        if (state_q == ST_OUT) begin
            dig_len  = digest_bits(mode_q);
            dig_last = 1'b1;
`ifdef SHA3_SHAKE_EN
            if (mode_q >= MODE_SHAKE128) begin
                dig_last = (rem_x <= rb_x);
                dig_len  = dig_last ? rem_x[10:0] : rate_bits;
            end
`endif
        end
    end

    sha3_blk_asm #(.IN_W(IN_W)) u_blk_asm (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .wr_i     (wr),
        .data_i   (in_data),
        .nbytes_i (beat_nb),
        .off_i    (base_off),
        .pad_i    (pad),
        .pad_off_i(pad_off),
        .rate_i   (rate_c),
        .suffix_i (sfx_c),
        .blk_o    (blk_data)
    );

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign dig_valid = (state_q == ST_OUT);
    assign dig_data  = dig_q;
    assign blk_first = (state_q == ST_SEND) && first_q;
`ifdef SHA3_SHAKE_EN
    assign blk_squeeze = (state_q == ST_SQZ) && !sent_q;
`else
    assign blk_squeeze = 1'b0;
`endif
    assign blk_valid = (state_q == ST_SEND) || blk_squeeze;

endmodule

// File: doc/sha3_stream_ctrl.md
SHA3_STREAM_CTRL -- requirements
Module: sha3_stream_ctrl

Interface
REQ-001 SHALL have parameter IN_W, 64, input beat width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter OLEN_W, 16, width of the requested SHAKE output length in bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mode_i  input  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; sampled on the first beat.
REQ-007 out_len_i  input  OLEN_W  SHAKE output length in bits, nonzero multiple of 8; sampled on the first beat.
REQ-008 in_valid / in_ready  input / output  1  message beat handshake.
REQ-009 in_data  input  IN_W  message bytes, byte k in bits [8k+7:8k].
REQ-010 in_last, in_bytes  input  1, clog2(IN_W/8)+1  final beat flag; valid byte count on the final beat (0..IN_W/8).
REQ-011 blk_valid / blk_ready  output / input  1  block request to the permutation engine.
REQ-012 blk_data, blk_first, blk_squeeze  output  1344, 1, 1  rate block zero-extended; first block of message (XOR with zero state); permute-only request.
REQ-013 perm_done  input  1  one-cycle pulse when the requested permutation completes.
REQ-014 state_i  input  1344  rate portion of the permutation state; valid when perm_done is high.
REQ-015 dig_valid / dig_ready  output / input  1  digest chunk handshake.
REQ-016 dig_data, dig_len, dig_last  output  1344, 11, 1  digest chunk; valid bits in the chunk; final chunk.
REQ-017 busy, err  output  1, 1  message in progress; sticky illegal-mode flag.

Function
REQ-018 Rates in bytes SHALL be 144, 136, 104, 72, 168, 136 for modes 0..5; domain suffix SHALL be 0x06 for SHA3 modes and 0x1F for SHAKE modes.
REQ-019 FSM states SHALL be IDLE, FILL, SEND, PERM, OUT, SQZ.
REQ-020 IDLE->FILL on the first accepted beat; FILL accumulates bytes at the running byte offset; in_ready is high only in IDLE and FILL.
REQ-021 When the block reaches rate bytes, or when in_last is accepted, FILL->SEND; blk_valid stays high until blk_ready; blk_data SHALL stay stable while blk_valid is high.
REQ-022 Padding: on the last block, the suffix byte SHALL be XORed at offset = message bytes in block, and 0x80 SHALL be XORed at offset rate-1; coincident offsets yield 0x86 or 0x9F.
REQ-023 If the message ends exactly on a rate boundary, a separate padding-only block SHALL follow.
REQ-024 SEND->PERM on handshake; PERM->FILL on perm_done if input remains, else PERM->OUT, capturing state_i.
REQ-025 Fixed modes: one chunk, dig_len 224/256/384/512, dig_last=1.
REQ-026 SHAKE: dig_len = min(remaining, rate*8); after a non-final dig handshake, OUT->SQZ issues blk_valid with blk_squeeze=1 and waits perm_done, then returns to OUT; remaining decrements by rate*8.
REQ-027 OUT->IDLE on the dig_last handshake; busy falls in the same cycle.
REQ-028 An in_last beat with in_bytes=0 SHALL be legal; an empty message produces one padding-only block.
REQ-029 Illegal mode: err set, beats accepted and dropped through in_last, no block or digest issued; err clears on the next first beat.

Reset
REQ-030 rst SHALL force IDLE from any state, including mid-block or mid-squeeze; in_ready=1 and all other outputs 0, offsets and counters 0.

Configuration
REQ-031 With SHA3_SHAKE_EN defined, modes 4 and 5 SHALL operate per REQ-026; without it, modes 4 and 5 SHALL be treated as illegal, the squeeze counter and SQZ state SHALL be omitted, and out_len_i SHALL be ignored.

Structure
REQ-032 Package sha3_pkg SHALL hold the mode enum, FSM state enum, rate-bytes function, suffix constants and the 1344 block-width constant.
REQ-033 Sub-module sha3_blk_asm SHALL perform byte-offset insertion and padding XOR into the block register.

Verification
REQ-034 SHA3-256 empty message -> one block, byte0=0x06, byte135=0x80, others 0; digest dig_len=256.
REQ-035 SHA3-256, 135 bytes -> single block with byte135=0x86.
REQ-036 SHA3-256, 136 bytes -> two blocks, the second padding-only (byte0=0x06, byte135=0x80), blk_first 1 then 0.
REQ-037 SHAKE128, out_len_i=3000 -> chunks of 1344, 1344 and 312 bits, two blk_squeeze requests, dig_last on the third chunk.
REQ-038 mode_i=7 -> err=1, no blk_valid, in_ready held high through in_last.
REQ-039 rst asserted during SQZ -> IDLE next cycle; a fresh SHA3-512 message then completes with dig_len=512.
